dot_product_sequencer: RTL and testbench

DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

---
 rtl/dot_product_sequencer_pkg.sv | 16 +
 rtl/dot_product_sequencer_if.sv | 56 +++++
 rtl/dot_product_sequencer.sv | 139 +++++++++++++
 tb/tb_dot_product_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_sequencer_pkg.sv
// Shared types and constants for the dot-product sequencer.
package dot_seq_pkg;

  // Job sequencing states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STREAM   = 3'd1,
    WAIT_RES = 3'd2,
    WRITE    = 3'd3,
    FINISH   = 3'd4
  } state_e;

  // Default number of cycles to wait for the engine before flagging an error.
  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/dot_product_sequencer_if.sv
// Bus bundle between the sequencer (master) and its environment (slave):
// job control, operand memories, dot-product engine and result memory.
//
// Strobe semantics: every *_en / *_valid signal qualifies its companion
// data for exactly the cycle it is high; there is no backpressure. Operand
// read data returns exactly one cycle after mem_rd_en. start is a request
// pulse only honoured while busy is low.
interface dot_product_sequencer_if
  import dot_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int VECTOR_WIDTH   = 4,
  parameter int ADDR_WIDTH     = 5,
  parameter int RES_ADDR_WIDTH = 3,
  parameter int RESULT_WIDTH   = 2*DATA_WIDTH + $clog2(VECTOR_WIDTH)
);
  // Job control
  logic                      start;
  logic                      abort;
  logic [RES_ADDR_WIDTH:0]   num_vectors;
  logic                      busy;
  logic                      done;
  logic                      error;
  // Operand memories (shared address)
  logic                      mem_rd_en;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem1_rdata;
  logic [DATA_WIDTH-1:0]     mem2_rdata;
  // Dot-product engine
  logic                      dp_data_valid;
  logic [DATA_WIDTH-1:0]     dp_mem1;
  logic [DATA_WIDTH-1:0]     dp_mem2;
  logic [RESULT_WIDTH-1:0]   dp_result;
  logic                      dp_result_valid;
  // Result memory
  logic                      res_wr_en;
  logic [RES_ADDR_WIDTH-1:0] res_wr_addr;
  logic [RESULT_WIDTH-1:0]   res_wr_data;
  // Debug view of the sequencer FSM
  state_e                    dbg_state;

  modport master (
    input  start, abort, num_vectors, mem1_rdata, mem2_rdata,
           dp_result, dp_result_valid,
    output busy, done, error, mem_rd_en, mem_addr, dp_data_valid,
           dp_mem1, dp_mem2, res_wr_en, res_wr_addr, res_wr_data, dbg_state
  );

  modport slave (
    output start, abort, num_vectors, mem1_rdata, mem2_rdata,
           dp_result, dp_result_valid,
    input  busy, done, error, mem_rd_en, mem_addr, dp_data_valid,
           dp_mem1, dp_mem2, res_wr_en, res_wr_addr, res_wr_data, dbg_state
  );

endinterface

// File: rtl/dot_product_sequencer.sv
// Dot-product job sequencer: streams num_vectors operand vectors from two
// memories into an external engine, collects each result into a result
// memory, and guards every engine wait with a timeout.
module dot_product_sequencer
  import dot_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int VECTOR_WIDTH   = 4,
  parameter int ADDR_WIDTH     = 5,
  parameter int RES_ADDR_WIDTH = 3,
  parameter int RESULT_WIDTH   = 2*DATA_WIDTH + $clog2(VECTOR_WIDTH),
  parameter int TIMEOUT        = DEFAULT_TIMEOUT
) (
  input logic                    clk,
  input logic                    rst_n,
  dot_product_sequencer_if.master bus
);

  localparam int EW = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int KW = RES_ADDR_WIDTH + 1;

  state_e                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;         // vector index
  logic [KW-1:0]           nv_q, nv_d;       // vectors in current job
  logic [EW-1:0]           i_q, i_d;         // element index within vector
  logic [TW-1:0]           t_q, t_d;         // WAIT_RES cycle counter
  logic                    err_q, err_d;
  logic                    dv_q, dv_d;
  logic [RESULT_WIDTH-1:0] wdata_q, wdata_d;

  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   addr;

  assign rd_en = (state_q == STREAM);
  // Address wraps naturally at ADDR_WIDTH bits.
  assign addr  = ADDR_WIDTH'(k_q) * ADDR_WIDTH'(VECTOR_WIDTH) + ADDR_WIDTH'(i_q);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      nv_q    <= '0;
      i_q     <= '0;
      t_q     <= '0;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      nv_q    <= nv_d;
      i_q     <= i_d;
      t_q     <= t_d;
      err_q   <= err_d;
      dv_q    <= dv_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic; abort overrides every non-idle decision.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    nv_d    = nv_q;
    i_d     = i_q;
    t_d     = t_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    // Element strobe is the read strobe one stage later, killed on abort.
    dv_d    = rd_en && !bus.abort;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          err_d   = 1'b0;
          k_d     = '0;
          i_d     = '0;
          t_d     = '0;
          nv_d    = bus.num_vectors;
          state_d = (bus.num_vectors != '0) ? STREAM : FINISH;
        end
      end
      STREAM: begin
        if (i_q == EW'(VECTOR_WIDTH - 1)) begin
          i_d     = '0;
          t_d     = '0;
          state_d = WAIT_RES;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      WAIT_RES: begin
        if (bus.dp_result_valid) begin
          wdata_d = bus.dp_result;
          state_d = WRITE;
        end else if (t_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      WRITE: begin
        if ((k_q + 1'b1) < nv_q) begin
          k_d     = k_q + 1'b1;
          state_d = STREAM;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      k_d     = '0;
      i_d     = '0;
      t_d     = '0;
      err_d   = err_q;
    end
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == FINISH);
  assign bus.error         = err_q;
  assign bus.mem_rd_en     = rd_en;
  assign bus.mem_addr      = rd_en ? addr : '0;
  assign bus.dp_data_valid = dv_q;
  assign bus.dp_mem1       = bus.mem1_rdata;
  assign bus.dp_mem2       = bus.mem2_rdata;
  assign bus.res_wr_en     = (state_q == WRITE);
  assign bus.res_wr_addr   = k_q[RES_ADDR_WIDTH-1:0];
  assign bus.res_wr_data   = wdata_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: memory and engine models, scoreboard of
// expected result writes, directed and random jobs.
module tb_dot_product_sequencer;

  localparam int DW  = 8;
  localparam int VW  = 4;
  localparam int AW  = 5;
  localparam int RAW = 3;
  localparam int RW  = 2*DW + $clog2(VW);
  localparam int TO  = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dot_product_sequencer_if #(
    .DATA_WIDTH(DW), .VECTOR_WIDTH(VW), .ADDR_WIDTH(AW),
    .RES_ADDR_WIDTH(RAW), .RESULT_WIDTH(RW)
  ) bus ();

  dot_product_sequencer #(
    .DATA_WIDTH(DW), .VECTOR_WIDTH(VW), .ADDR_WIDTH(AW),
    .RES_ADDR_WIDTH(RAW), .RESULT_WIDTH(RW), .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- checking ----------------
  int checks;
  int failures;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [DW-1:0] mem1 [2**AW];
  logic [DW-1:0] mem2 [2**AW];

  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem1_rdata <= mem1[bus.mem_addr];
      bus.mem2_rdata <= mem2[bus.mem_addr];
    end
  end

  // ---------------- engine model (2-cycle result delay) ----------------
  bit          eng_on;
  logic [RW-1:0] eng_acc;
  int          eng_cnt;
  logic        eng_s1;

  always @(posedge clk) begin
    if (!rst_n || !bus.busy) begin
      eng_acc = '0;
      eng_cnt = 0;
      eng_s1 <= 1'b0;
      bus.dp_result_valid <= 1'b0;
    end else begin
      bus.dp_result_valid <= eng_s1;
      eng_s1 <= 1'b0;
      if (bus.dp_data_valid) begin
        eng_acc = eng_acc + RW'(bus.dp_mem1) * RW'(bus.dp_mem2);
        if (eng_cnt == VW - 1) begin
          bus.dp_result <= eng_acc;
          eng_s1 <= eng_on;
          eng_acc = '0;
          eng_cnt = 0;
        end else begin
          eng_cnt++;
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [RW-1:0]  exp_q[$];
  logic [RAW-1:0] exp_addr_q[$];
  logic [AW-1:0]  addr_log[$];
  int job_s;
  int rd_cnt, wr_cnt, done_cnt, dv_rise, dv_cnt;
  int first_rd, first_dv, wr_rel, done_rel;
  logic err_at_done, dv_prev;

  task automatic clear_stats();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; dv_rise = 0; dv_cnt = 0;
    first_rd = -1; first_dv = -1; wr_rel = -1; done_rel = -1;
    err_at_done = 1'b0; dv_prev = 1'b0;
    addr_log.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_rd_en) begin
        if (rd_cnt == 0) first_rd = cyc - job_s;
        addr_log.push_back(bus.mem_addr);
        rd_cnt++;
      end
      if (bus.dp_data_valid) begin
        if (dv_cnt == 0) first_dv = cyc - job_s;
        if (!dv_prev) dv_rise++;
        dv_cnt++;
      end
      dv_prev = bus.dp_data_valid;
      if (bus.res_wr_en) begin
        wr_cnt++;
        wr_rel = cyc - job_s;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write", 1, 0);
        end else begin
          check_eq("wr_data", bus.res_wr_data, exp_q.pop_front());
          check_eq("wr_addr", bus.res_wr_addr, exp_addr_q.pop_front());
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_rel = cyc - job_s;
        err_at_done = bus.error;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [RW-1:0] dot_of(input int k);
    logic [RW-1:0] s;
    int idx;
    s = '0;
    for (int i = 0; i < VW; i++) begin
      idx = (k * VW + i) % (2**AW);
      s = s + RW'(mem1[idx]) * RW'(mem2[idx]);
    end
    return s;
  endfunction

  task automatic push_job(input int nv);
    for (int k = 0; k < nv; k++) begin
      exp_q.push_back(dot_of(k));
      exp_addr_q.push_back(RAW'(k));
    end
  endtask

  // Drives a one-cycle start; returns at the negedge of relative cycle 1.
  task automatic launch(input int nv);
    clear_stats();
    @(negedge clk);
    bus.num_vectors = (RAW+1)'(nv);
    bus.start = 1'b1;
    job_s = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    while (done_cnt == 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check_eq(tag, done_cnt, 1);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ctl"}, {bus.busy, bus.done, bus.error, bus.mem_rd_en,
                             bus.dp_data_valid, bus.res_wr_en}, 0);
    check_eq({tag, "_addr"}, bus.mem_addr, 0);
    check_eq({tag, "_waddr"}, bus.res_wr_addr, 0);
    check_eq({tag, "_wdata"}, bus.res_wr_data, 0);
  endtask

  task automatic load_basic();
    for (int i = 0; i < VW; i++) begin
      mem1[i] = DW'(i + 1);
      mem2[i] = DW'(i + 5);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    checks = 0; failures = 0; cyc = 0; job_s = 0;
    eng_on = 1'b1;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.num_vectors = '0;
    bus.mem1_rdata = '0; bus.mem2_rdata = '0;
    bus.dp_result = '0; bus.dp_result_valid = 1'b0;
    for (int a = 0; a < 2**AW; a++) begin
      mem1[a] = DW'($urandom_range(0, 255));
      mem2[a] = DW'($urandom_range(0, 255));
    end
    clear_stats();
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic single vector: 1*5+2*6+3*7+4*8 = 70.
    load_basic();
    check_eq("basic_model", dot_of(0), 70);
    push_job(1);
    launch(1);
    wait_done("basic_done", 60);
    check_eq("basic_first_rd", first_rd, 1);
    check_eq("basic_rd_cnt", rd_cnt, VW);
    check_eq("basic_first_dv", first_dv, 2);
    check_eq("basic_dv_cnt", dv_cnt, VW);
    check_eq("basic_wr_rel", wr_rel, 8);
    check_eq("basic_done_rel", done_rel, 9);
    check_eq("basic_error", err_at_done, 0);
    repeat (2) @(negedge clk);
    check_eq("basic_idle_busy", bus.busy, 0);

    // Two vectors of all-255 operands.
    for (int a = 0; a < 2*VW; a++) begin
      mem1[a] = 8'hFF;
      mem2[a] = 8'hFF;
    end
    push_job(2);
    launch(2);
    wait_done("max_done", 80);
    check_eq("max_wr_cnt", wr_cnt, 2);
    check_eq("max_dv_gap", dv_rise, 2);
    check_eq("max_rd_cnt", rd_cnt, 2*VW);
    for (int a = 0; a < 2*VW; a++)
      if (a < addr_log.size()) check_eq("max_addr", addr_log[a], a);
    check_eq("max_error", err_at_done, 0);

    // Empty job.
    launch(0);
    wait_done("empty_done", 10);
    check_eq("empty_done_rel", done_rel, 1);
    check_eq("empty_rd", rd_cnt, 0);
    check_eq("empty_wr", wr_cnt, 0);

    // Engine never answers: timeout, error, no write.
    eng_on = 1'b0;
    launch(1);
    wait_done("to_done", 60);
    check_eq("to_done_rel", done_rel, 5 + TO);
    check_eq("to_error", err_at_done, 1);
    check_eq("to_wr", wr_cnt, 0);
    repeat (3) @(negedge clk);
    check_eq("to_error_sticky", bus.error, 1);
    eng_on = 1'b1;
    load_basic();
    push_job(1);
    launch(1);
    check_eq("to_error_cleared", bus.error, 0);
    wait_done("to_next_done", 60);

    // Repeated start while busy, then abort in STREAM.
    launch(3);
    bus.start = 1'b1;
    bus.num_vectors = 1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_eq("abort_ctl", {bus.busy, bus.mem_rd_en, bus.dp_data_valid,
                           bus.res_wr_en, bus.done}, 0);
    check_eq("abort_rd_cnt", rd_cnt, 2);
    if (addr_log.size() > 1) check_eq("abort_restart_ignored", addr_log[1], 1);
    repeat (30) @(negedge clk);
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_no_wr", wr_cnt, 0);
    check_eq("abort_error", bus.error, 0);

    // Random jobs.
    for (int j = 0; j < 4; j++) begin
      int nv;
      nv = $urandom_range(1, 2**RAW);
      for (int a = 0; a < 2**AW; a++) begin
        mem1[a] = DW'($urandom_range(0, 255));
        mem2[a] = DW'($urandom_range(0, 255));
      end
      push_job(nv);
      launch(nv);
      wait_done("rand_done", 20 * nv + 20);
      check_eq("rand_wr_cnt", wr_cnt, nv);
      check_eq("rand_error", err_at_done, 0);
    end

    // Reset pulse during WAIT_RES.
    load_basic();
    launch(1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outs("midrst");
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("midrst_no_done", done_cnt, 0);
    check_eq("midrst_no_wr", wr_cnt, 0);
    push_job(1);
    launch(1);
    wait_done("midrst_next_done", 60);
    check_eq("midrst_next_wr", wr_cnt, 1);
    check_eq("midrst_next_rel", done_rel, 9);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
